// File: rtl/pipe_rx_descrambler.sv
// Receive-side PCIe lane byte descrambler: Gen1/2 16-bit and Gen3+ 23-bit
// Galois LFSRs, per-byte advance/XOR gating, one-cycle registered output.
module pipe_rx_descrambler #(
    parameter logic [22:0] GEN3_SEED  = 23'h1DBFBC,
    parameter logic [15:0] GEN12_SEED = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  GEN,
    input  logic [1:0]  LFSRSel,
    input  logic [31:0] dataIn,
    input  logic [3:0]  dataInK,
    input  logic        dataValid,
    input  logic        patternReset,
    input  logic [3:0]  advance,
    input  logic [3:0]  descramblingEnable,
    output logic [31:0] dataOut,
    output logic [3:0]  dataOutK,
    output logic        dataOutValid
);

    localparam logic [15:0] POLY12 = 16'h0039;
    localparam logic [22:0] POLY3  = 23'h210125;

    logic [15:0] r_lfsr12;
    logic [22:0] r_lfsr3;
    logic [31:0] r_data;
    logic [3:0]  r_k;
    logic        r_vld;

    logic        w_gen3;
    logic [3:0]  w_act;
    logic [15:0] w_s12;
    logic [22:0] w_s3;
    logic [7:0]  w_scr;
    logic        w_xor;
    logic [31:0] w_data;

    assign w_gen3 = (GEN >= 3'd3);

    always_comb begin
        case (LFSRSel)
            2'd0:    w_act = 4'b0001;
            2'd1:    w_act = 4'b0011;
            default: w_act = 4'b1111;
        endcase
    end

    // Bytes chain through the LFSR in order; only the selected generation's
    // register ever steps, so the other one holds its value for free.
    always_comb begin
        w_s12  = r_lfsr12;
        w_s3   = r_lfsr3;
        w_data = dataIn;
        w_scr  = '0;
        w_xor  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_scr = '0;
            if (w_act[i] && advance[i] && !patternReset) begin
                for (int k = 0; k < 8; k++) begin
                    if (w_gen3) begin
                        w_scr[k] = w_s3[22];
                        w_s3     = {w_s3[21:0], 1'b0} ^ (w_s3[22] ? POLY3 : 23'd0);
                    end else begin
                        w_scr[k] = w_s12[15];
                        w_s12    = {w_s12[14:0], 1'b0} ^ (w_s12[15] ? POLY12 : 16'd0);
                    end
                end
            end
            w_xor = w_gen3 ? descramblingEnable[i] : ~dataInK[i];
            if (w_xor)
                w_data[8*i +: 8] = dataIn[8*i +: 8] ^ w_scr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr12 <= GEN12_SEED;
            r_lfsr3  <= GEN3_SEED;
            r_data   <= '0;
            r_k      <= '0;
            r_vld    <= 1'b0;
        end else if (dataValid) begin
            r_data <= w_data;
            r_k    <= dataInK;
            r_vld  <= 1'b1;
            if (patternReset) begin
                if (w_gen3) r_lfsr3  <= GEN3_SEED;
                else        r_lfsr12 <= GEN12_SEED;
            end else begin
                r_lfsr12 <= w_s12;
                r_lfsr3  <= w_s3;
            end
        end else begin
            r_vld <= 1'b0;
        end
    end

    assign dataOut      = r_data;
    assign dataOutK     = r_k;
    assign dataOutValid = r_vld;

endmodule

// File: tb/tb_pipe_rx_descrambler.sv
// Scoreboard bench for pipe_rx_descrambler: the model tracks a byte offset into
// precomputed keystreams per generation; a monitor compares every output cycle.
module tb_pipe_rx_descrambler;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  GEN;
    logic [1:0]  LFSRSel;
    logic [31:0] dataIn;
    logic [3:0]  dataInK;
    logic        dataValid;
    logic        patternReset;
    logic [3:0]  advance;
    logic [3:0]  descramblingEnable;
    logic [31:0] dataOut;
    logic [3:0]  dataOutK;
    logic        dataOutValid;

    always #5 clk = ~clk;

    pipe_rx_descrambler dut (
        .clk(clk), .reset(reset), .GEN(GEN), .LFSRSel(LFSRSel),
        .dataIn(dataIn), .dataInK(dataInK), .dataValid(dataValid),
        .patternReset(patternReset), .advance(advance),
        .descramblingEnable(descramblingEnable),
        .dataOut(dataOut), .dataOutK(dataOutK), .dataOutValid(dataOutValid)
    );

    typedef struct {
        logic        vld;
        logic [31:0] d;
        logic [3:0]  k;
        bit          chk_k;
        int          id;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int beat_id = 0;

    localparam int KS_LEN = 8192;
    byte unsigned ks12[KS_LEN];
    byte unsigned ks3[KS_LEN];
    int pos12, pos3;
    logic [31:0] last_d;
    logic [3:0]  last_k;

    // Keystream from the polynomial definition, one bit per shift.
    task automatic build_ks();
        int unsigned s;
        int unsigned b;
        int unsigned msb;
        s = 32'hFFFF;
        for (int n = 0; n < KS_LEN; n++) begin
            b = 0;
            for (int k = 0; k < 8; k++) begin
                msb = (s >> 15) & 1;
                b = b | (msb << k);
                s = ((s << 1) & 32'hFFFF) ^ (msb != 0 ? 32'h0039 : 0);
            end
            ks12[n] = b[7:0];
        end
        s = 32'h1DBFBC;
        for (int n = 0; n < KS_LEN; n++) begin
            b = 0;
            for (int k = 0; k < 8; k++) begin
                msb = (s >> 22) & 1;
                b = b | (msb << k);
                s = ((s << 1) & 32'h7FFFFF) ^ (msb != 0 ? 32'h210125 : 0);
            end
            ks3[n] = b[7:0];
        end
    endtask

    task automatic beat(input logic rst, input logic vld, input logic [2:0] gen,
                        input logic [1:0] sel, input logic [31:0] d, input logic [3:0] k,
                        input logic pr, input logic [3:0] adv, input logic [3:0] de,
                        input logic ov, input logic [31:0] ovd);
        exp_t e;
        int width;
        bit g3, x;
        byte unsigned kb;
        logic [31:0] o;
        reset = rst; dataValid = vld; GEN = gen; LFSRSel = sel; dataIn = d;
        dataInK = k; patternReset = pr; advance = adv; descramblingEnable = de;
        e.id = beat_id; beat_id++;
        if (rst) begin
            pos12 = 0; pos3 = 0; last_d = '0; last_k = '0;
            e.vld = 1'b0; e.d = '0; e.k = '0; e.chk_k = 1'b1;
        end else if (!vld) begin
            e.vld = 1'b0; e.d = last_d; e.k = last_k; e.chk_k = 1'b0;
        end else begin
            g3 = (gen >= 3);
            width = (sel == 0) ? 1 : (sel == 1) ? 2 : 4;
            o = d;
            if (pr) begin
                if (g3) pos3 = 0; else pos12 = 0;
            end else begin
                for (int i = 0; i < width; i++) begin
                    kb = 0;
                    if (adv[i]) begin
                        if (g3) begin kb = ks3[pos3]; pos3++; end
                        else begin kb = ks12[pos12]; pos12++; end
                    end
                    x = g3 ? de[i] : !k[i];
                    if (x) o[8*i +: 8] = d[8*i +: 8] ^ kb;
                end
            end
            if (ov) o = ovd;
            last_d = o; last_k = k;
            e.vld = 1'b1; e.d = o; e.k = k; e.chk_k = 1'b1;
        end
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (dataOutValid !== e.vld || dataOut !== e.d || (e.chk_k && dataOutK !== e.k)) begin
                failures++;
                $display("FAIL beat%0d: got vld=%b d=%h k=%h, want vld=%b d=%h k=%h",
                         e.id, dataOutValid, dataOut, dataOutK, e.vld, e.d, e.k);
            end
        end
    end

    logic [31:0] rd;

    initial begin
        build_ks();
        // Reset
        beat(1, 0, 3'd2, 2'd2, 32'h0, 4'h0, 0, 4'hF, 4'h0, 0, 0);
        beat(1, 1, 3'd2, 2'd2, 32'hDEADBEEF, 4'h0, 0, 4'hF, 4'h0, 0, 0);
        // Gen1/2 known sequence
        beat(0, 1, 3'd2, 2'd2, 32'h0, 4'h0, 0, 4'hF, 4'h0, 1, 32'h14C017FF);
        beat(0, 1, 3'd2, 2'd2, 32'h0, 4'h0, 0, 4'hF, 4'h0, 1, 32'h8202E7B2);
        // Round trip across widths, gaps included
        for (int n = 0; n < 60; n++)
            beat(0, ($urandom_range(0, 4) != 0), 3'($urandom_range(0, 2)),
                 2'(n % 3), $urandom, 4'h0, 0, 4'hF, 4'($urandom), 0, 0);
        // COM reset then SKP hold
        rd = $urandom;
        beat(0, 1, 3'd1, 2'd2, {rd[31:8], 8'hBC}, 4'b0001, 1, 4'hF, 4'h0, 1, {rd[31:8], 8'hBC});
        rd = $urandom;
        beat(0, 1, 3'd1, 2'd2, {rd[31:16], 8'h1C, rd[7:0]}, 4'b0010, 0, 4'b1101, 4'h0, 1,
             {rd[31:24] ^ 8'hC0, rd[23:16] ^ 8'h17, 8'h1C, rd[7:0] ^ 8'hFF});
        // Gen3 gating
        beat(0, 1, 3'd3, 2'd2, $urandom, 4'h0, 1, 4'hF, 4'hF, 0, 0);
        beat(0, 1, 3'd3, 2'd2, $urandom, 4'hF, 0, 4'hF, 4'b0001, 0, 0);
        beat(0, 1, 3'd3, 2'd2, $urandom, 4'h0, 0, 4'h0, 4'hF, 0, 0);
        beat(0, 0, 3'd3, 2'd2, $urandom, 4'h0, 1, 4'hF, 4'hF, 0, 0);
        beat(0, 1, 3'd4, 2'd3, $urandom, 4'h0, 0, 4'hF, 4'hF, 0, 0);
        // Mid-stream reset, then Gen1/2 restarts at seed
        beat(0, 1, 3'd2, 2'd2, $urandom, 4'h0, 0, 4'hF, 4'h0, 0, 0);
        beat(1, 1, 3'd2, 2'd2, $urandom, 4'h0, 0, 4'hF, 4'h0, 0, 0);
        beat(0, 1, 3'd2, 2'd2, 32'h0, 4'h0, 0, 4'hF, 4'h0, 1, 32'h14C017FF);
        // Random mix
        for (int n = 0; n < 1200; n++)
            beat(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) != 0),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom,
                 4'($urandom), ($urandom_range(0, 15) == 0), 4'($urandom),
                 4'($urandom), 0, 0);
        beat(0, 0, 3'd2, 2'd2, 32'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0);
        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
